dc_spi_writer: RTL

Downstream of the DC frame dispatcher. Captures each validated DC frame (62 words plus a 5-bit channel select) and serializes it, MSB first, over a SPI-mode-0 link to the DAC selected by the channel index, one chip-select per DAC. A one-frame pending slot absorbs a frame arriving while a transfer is in progress, because the dispatcher has no backpressure.

---
 rtl/dc_pkg.sv | 22 ++
 rtl/spi_word_shifter.sv | 78 +++++++
 rtl/dc_spi_writer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/dc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dc_pkg
// Brief    : Shared types and defaults for the DC-frame SPI writer.
// Revision : 1.0 - initial release
// ============================================================================
package dc_pkg;

  localparam int DC_DAC_CHANNEL = 24;
  localparam int DC_FRAME_WORDS = 62;

  typedef logic [DC_FRAME_WORDS-1:0][31:0] frame_t;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_SHIFT = 3'd1;
  localparam state_t ST_GAP   = 3'd2;
  localparam state_t ST_LDAC  = 3'd3;
  localparam state_t ST_DONE  = 3'd4;

endpackage
`default_nettype wire

// File: rtl/spi_word_shifter.sv
`default_nettype none
// ============================================================================
// Module   : spi_word_shifter
// Brief    : SPI mode-0 word serializer: SCLK divider plus MSB-first shifter.
// Revision : 1.0 - initial release
// ============================================================================
module spi_word_shifter #(
  parameter int WORD_BITS = 32,
  parameter int SCLK_DIV  = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [31:0] i_word,
  output logic        o_done,
  output logic        o_sclk,
  output logic        o_mosi
);

  localparam logic [15:0] c_div_last = 16'(SCLK_DIV - 1);
  localparam logic [5:0]  c_bit_last = 6'(WORD_BITS - 1);

  logic        active_q, active_d;
  logic        sclk_q, sclk_d;
  logic [15:0] div_q, div_d;
  logic [5:0]  bit_q, bit_d;
  logic [31:0] sreg_q, sreg_d;
  logic        tick;

  assign tick   = active_q && (div_q == c_div_last);
  assign o_done = tick && sclk_q && (bit_q == c_bit_last);
  assign o_sclk = sclk_q;
  assign o_mosi = sreg_q[31];

  always_comb begin
    active_d = active_q;
    sclk_d   = sclk_q;
    div_d    = div_q;
    bit_d    = bit_q;
    sreg_d   = sreg_q;
    if (i_start) begin
      active_d = 1'b1;
      sclk_d   = 1'b0;
      div_d    = '0;
      bit_d    = '0;
      sreg_d   = i_word;
    end else if (tick) begin
      div_d  = '0;
      sclk_d = ~sclk_q;
      // Data moves on the falling edge so it is stable at the next rise.
      if (sclk_q) begin
        sreg_d = {sreg_q[30:0], 1'b0};
        bit_d  = bit_q + 1'b1;
        if (bit_q == c_bit_last) active_d = 1'b0;
      end
    end else if (active_q) begin
      div_d = div_q + 16'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      active_q <= 1'b0;
      sclk_q   <= 1'b0;
      div_q    <= '0;
      bit_q    <= '0;
      sreg_q   <= '0;
    end else begin
      active_q <= active_d;
      sclk_q   <= sclk_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      sreg_q   <= sreg_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dc_spi_writer.sv
`default_nettype none
// ============================================================================
// Module   : dc_spi_writer
// Brief    : Captures DC frames and streams them word-by-word to one of
//            DAC_CHANNEL SPI DACs, with a one-frame pending slot.
//            Macro DC_SPI_LDAC_EN adds an o_ldac_n pulse after each frame.
// Revision : 1.0 - initial release
// ============================================================================
module dc_spi_writer
  import dc_pkg::*;
#(
  parameter int DAC_CHANNEL = DC_DAC_CHANNEL,
  parameter int FRAME_WORDS = DC_FRAME_WORDS,
  parameter int WORD_BITS   = 32,
  parameter int SCLK_DIV    = 4,
  parameter int CS_GAP      = 2
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [FRAME_WORDS-1:0][31:0] i_dc_regs,
  input  logic [4:0]                   i_channel_sel,
  input  logic                         i_valid_frame,
  input  logic                         i_err_clr,
  output logic                         o_spi_sclk,
  output logic                         o_spi_mosi,
  output logic [DAC_CHANNEL-1:0]       o_spi_cs_n,
  output logic                         o_busy,
  output logic                         o_frame_done,
  output logic                         o_overflow,
`ifdef DC_SPI_LDAC_EN
  output logic                         o_ldac_n,
`endif
  output logic                         o_bad_chan
);

  localparam int                WIDX_W      = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam logic [WIDX_W-1:0] c_last_word = WIDX_W'(FRAME_WORDS - 1);
  localparam logic [15:0]       c_gap_last  = 16'(CS_GAP - 1);
  localparam logic [5:0]        c_nchan     = 6'(DAC_CHANNEL);
`ifdef DC_SPI_LDAC_EN
  localparam int                LDAC_WIDTH  = 4;
  localparam logic [15:0]       c_ldac_last = 16'(LDAC_WIDTH - 1);
`endif

  state_t                       state_q, state_d;
  logic [WIDX_W-1:0]            word_q, word_d;
  logic [15:0]                  cnt_q, cnt_d;
  logic [4:0]                   sel_q, sel_d;
  logic [4:0]                   pend_sel_q, pend_sel_d;
  logic                         pend_full_q, pend_full_d;
  logic                         ovf_q, ovf_d;
  logic                         bad_q, bad_d;
  logic [FRAME_WORDS-1:0][31:0] active_q, active_d;
  logic [FRAME_WORDS-1:0][31:0] pend_q, pend_d;

  logic        chan_ok, good, start, shift_done, take_new;
  logic [31:0] start_word;

  assign chan_ok = ({1'b0, i_channel_sel} < c_nchan);
  assign good    = i_valid_frame && chan_ok;

  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    cnt_d       = cnt_q;
    sel_d       = sel_q;
    active_d    = active_q;
    pend_d      = pend_q;
    pend_sel_d  = pend_sel_q;
    pend_full_d = pend_full_q;
    ovf_d       = ovf_q & ~i_err_clr;
    bad_d       = bad_q & ~i_err_clr;
    start       = 1'b0;
    start_word  = '0;
    take_new    = 1'b0;

    if (i_valid_frame && !chan_ok) bad_d = 1'b1;

    case (state_q)
      ST_IDLE: if (good) take_new = 1'b1;
      ST_SHIFT: begin
        if (shift_done) begin
          cnt_d   = '0;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (cnt_q == c_gap_last) begin
          cnt_d = '0;
          if (word_q == c_last_word) begin
`ifdef DC_SPI_LDAC_EN
            state_d = ST_LDAC;
`else
            state_d = ST_DONE;
`endif
          end else begin
            word_d     = word_q + 1'b1;
            start      = 1'b1;
            start_word = active_q[word_q + 1'b1];
            state_d    = ST_SHIFT;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
`ifdef DC_SPI_LDAC_EN
      ST_LDAC: begin
        if (cnt_q == c_ldac_last) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
`endif
      ST_DONE: begin
        if (pend_full_q) begin
          active_d    = pend_q;
          sel_d       = pend_sel_q;
          word_d      = '0;
          start       = 1'b1;
          start_word  = pend_q[0];
          state_d     = ST_SHIFT;
          pend_full_d = 1'b0;
        end else if (good) begin
          // Nothing pending: a frame arriving now goes straight out.
          take_new = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (take_new) begin
      active_d   = i_dc_regs;
      sel_d      = i_channel_sel;
      word_d     = '0;
      start      = 1'b1;
      start_word = i_dc_regs[0];
      state_d    = ST_SHIFT;
    end else if (good && state_q != ST_IDLE) begin
      // A slot being promoted this cycle is free for the incoming frame.
      if (!pend_full_q || state_q == ST_DONE) begin
        pend_d      = i_dc_regs;
        pend_sel_d  = i_channel_sel;
        pend_full_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      word_q      <= '0;
      cnt_q       <= '0;
      sel_q       <= '0;
      pend_sel_q  <= '0;
      pend_full_q <= 1'b0;
      ovf_q       <= 1'b0;
      bad_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      pend_sel_q  <= pend_sel_d;
      pend_full_q <= pend_full_d;
      ovf_q       <= ovf_d;
      bad_q       <= bad_d;
    end
  end

  // Payload storage is qualified by state/pend_full, so it needs no reset.
  always_ff @(posedge i_clk) begin
    active_q <= active_d;
    pend_q   <= pend_d;
  end

  spi_word_shifter #(
    .WORD_BITS (WORD_BITS),
    .SCLK_DIV  (SCLK_DIV)
  ) u_shifter (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_start (start),
    .i_word  (start_word),
    .o_done  (shift_done),
    .o_sclk  (o_spi_sclk),
    .o_mosi  (o_spi_mosi)
  );

  assign o_spi_cs_n   = (state_q == ST_SHIFT) ? ~(DAC_CHANNEL'(1) << sel_q) : '1;
  assign o_busy       = (state_q != ST_IDLE) || pend_full_q;
  assign o_frame_done = (state_q == ST_DONE);
  assign o_overflow   = ovf_q;
  assign o_bad_chan   = bad_q;
`ifdef DC_SPI_LDAC_EN
  assign o_ldac_n     = (state_q != ST_LDAC);
`endif

endmodule
`default_nettype wire
